// File: rtl/sensor_pkg.sv
// Shared types and default constants for the vehicle loop sensor conditioner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sensor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    PRESENT,
    HOLD,
    FAULT
  } sensor_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 8;
  localparam int HOLD_CYCLES_DEF     = 16;
  localparam int STUCK_CYCLES_DEF    = 1000;
  localparam int CNT_W_DEF           = 8;

  // Debounce and hold timers cover up to 255 cycles; the stuck counter up to 65535.
  localparam int TMR_W   = 8;
  localparam int STUCK_W = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// Latency: 2 clk edges from input to output.
// Backpressure: none; free-running.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  // Capture the asynchronous input in two stages; both clear on synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/vehicle_sensor_conditioner.sv
// Debounces an inductive-loop detector into a held vehicle request plus a saturating vehicle count.
// Latency: request rises DEBOUNCE_CYCLES+1 edges after the loop goes high, falls HOLD_CYCLES+2 edges after it clears.
// Backpressure: none. Stuck-high detection is built only when SENSOR_STUCK_DET_EN is defined.
module vehicle_sensor_conditioner
  import sensor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF,
  parameter int STUCK_CYCLES    = STUCK_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             loop_raw,
  input  logic             count_clr,
  output logic             sensor,
  output logic [CNT_W-1:0] vehicle_count,
  output logic             stuck_fault
);

  localparam logic [TMR_W-1:0] DEB_LAST  = TMR_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);

  logic                 loop_sync;
  sensor_state_t        state_q;
  logic [TMR_W-1:0]     deb_cnt_q;
  logic [TMR_W-1:0]     hold_tmr_q;
  logic                 sensor_q;
  logic                 stuck_fault_q;
  logic [CNT_W-1:0]     count_q;
  logic [CNT_W-1:0]     count_inc_d;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (loop_raw),
    .q_o   (loop_sync)
  );

  // Saturating increment: the count parks at all-ones instead of wrapping.
  assign count_inc_d = (&count_q) ? count_q : count_q + CNT_W'(1);

`ifdef SENSOR_STUCK_DET_EN
  localparam logic [STUCK_W-1:0] STUCK_LAST = STUCK_W'(STUCK_CYCLES - 1);
  logic [STUCK_W-1:0] stuck_cnt_q;
`else
  logic [STUCK_W-1:0] unused_stuck_cfg;
  assign unused_stuck_cfg = STUCK_W'(STUCK_CYCLES);
`endif

  // Detection FSM with its timers and registered outputs; outputs change in the transition branches.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      deb_cnt_q     <= '0;
      hold_tmr_q    <= '0;
      sensor_q      <= 1'b0;
      stuck_fault_q <= 1'b0;
      count_q       <= '0;
`ifdef SENSOR_STUCK_DET_EN
      stuck_cnt_q   <= '0;
`endif
    end else begin
      // A clear on its own zeroes the count; a same-edge increment overrides it with 1 below.
      if (count_clr) count_q <= '0;
      case (state_q)
        IDLE: begin
          if (loop_sync) begin
            state_q   <= ARM;
            deb_cnt_q <= TMR_W'(1);
          end
        end
        ARM: begin
          if (!loop_sync) begin
            state_q   <= IDLE;
            deb_cnt_q <= '0;
          end else if (deb_cnt_q == DEB_LAST) begin
            state_q  <= PRESENT;
            sensor_q <= 1'b1;
            count_q  <= count_clr ? CNT_W'(1) : count_inc_d;
`ifdef SENSOR_STUCK_DET_EN
            stuck_cnt_q <= '0;
`endif
          end else begin
            deb_cnt_q <= deb_cnt_q + TMR_W'(1);
          end
        end
        PRESENT: begin
          if (!loop_sync) begin
            state_q    <= HOLD;
            hold_tmr_q <= HOLD_LOAD;
`ifdef SENSOR_STUCK_DET_EN
          end else if (stuck_cnt_q == STUCK_LAST) begin
            state_q       <= FAULT;
            sensor_q      <= 1'b0;
            stuck_fault_q <= 1'b1;
            deb_cnt_q     <= '0;
          end else begin
            stuck_cnt_q <= stuck_cnt_q + STUCK_W'(1);
`endif
          end
        end
        HOLD: begin
          if (loop_sync) begin
            // Same vehicle still over the loop: resume without counting.
            state_q <= PRESENT;
`ifdef SENSOR_STUCK_DET_EN
            stuck_cnt_q <= '0;
`endif
          end else if (hold_tmr_q == '0) begin
            state_q   <= IDLE;
            sensor_q  <= 1'b0;
            deb_cnt_q <= '0;
          end else begin
            hold_tmr_q <= hold_tmr_q - TMR_W'(1);
          end
        end
`ifdef SENSOR_STUCK_DET_EN
        FAULT: begin
          // Leave only after the loop has read clear for DEBOUNCE_CYCLES in a row.
          if (loop_sync) begin
            deb_cnt_q <= '0;
          end else if (deb_cnt_q == DEB_LAST) begin
            state_q       <= IDLE;
            stuck_fault_q <= 1'b0;
            deb_cnt_q     <= '0;
          end else begin
            deb_cnt_q <= deb_cnt_q + TMR_W'(1);
          end
        end
`endif
        default: begin
          state_q       <= IDLE;
          sensor_q      <= 1'b0;
          stuck_fault_q <= 1'b0;
          deb_cnt_q     <= '0;
        end
      endcase
    end
  end

  assign sensor        = sensor_q;
  assign vehicle_count = count_q;
  assign stuck_fault   = stuck_fault_q;

endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
// Scoreboard bench: stimulus pushes expected outputs per edge, a negedge monitor pops and compares.
// Two DUTs share inputs: 8-bit count and 2-bit count (saturation).
`timescale 1ns/1ps
module tb_vehicle_sensor_conditioner;
  import sensor_pkg::*;

  localparam int D = 8;
  localparam int H = 16;
  localparam int S = 1000;
`ifdef SENSOR_STUCK_DET_EN
  localparam bit STUCK_EN = 1'b1;
`else
  localparam bit STUCK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       loop_raw;
  logic       count_clr;
  logic       sensor_a, stuck_a, sensor_b, stuck_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  always #5 clk = ~clk;

  vehicle_sensor_conditioner #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .STUCK_CYCLES(S), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .loop_raw(loop_raw), .count_clr(count_clr),
    .sensor(sensor_a), .vehicle_count(cnt_a), .stuck_fault(stuck_a));

  vehicle_sensor_conditioner #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .STUCK_CYCLES(S), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .loop_raw(loop_raw), .count_clr(count_clr),
    .sensor(sensor_b), .vehicle_count(cnt_b), .stuck_fault(stuck_b));

  typedef struct packed {
    logic       sensor;
    logic       stuck;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model: run lengths of the synchronised stream and a coarse mode.
  localparam int M_OFF = 0, M_ON = 1, M_FLT = 2;
  bit m_hist0, m_hist1;   // raw as seen one and two edges ago
  int m_hi, m_lo, m_mode, m_pres_start, m_veh;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, act, req, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_edge(input bit raw, input bit clr, input bit rstn);
    bit s;
    int inc;
    if (!rstn) begin
      m_hist0 = 0; m_hist1 = 0; m_hi = 0; m_lo = 0; m_mode = M_OFF; m_veh = 0;
    end else begin
      s = m_hist1;
      if (s) begin m_hi++; m_lo = 0; end else begin m_lo++; m_hi = 0; end
      inc = 0;
      case (m_mode)
        M_OFF: if (s && m_hi == D) begin m_mode = M_ON; inc = 1; m_pres_start = m_hi; end
        M_ON: begin
          if (s) begin
            if (m_hi == 1) m_pres_start = 1;
            else if (STUCK_EN && (m_hi - m_pres_start) == S) m_mode = M_FLT;
          end else if (m_lo == H + 1) begin
            m_mode = M_OFF;
          end
        end
        default: if (!s && m_lo == D) m_mode = M_OFF;
      endcase
      m_veh = clr ? inc : m_veh + inc;
      m_hist1 = m_hist0;
      m_hist0 = raw;
    end
  endtask

  task automatic step(input bit raw, input bit clr, input bit rstn);
    exp_t e;
    loop_raw  = raw;
    count_clr = clr;
    rst_n     = rstn;
    model_edge(raw, clr, rstn);
    e.sensor = (m_mode == M_ON);
    e.stuck  = (m_mode == M_FLT);
    e.cnt_a  = 8'(sat(m_veh, 255));
    e.cnt_b  = 2'(sat(m_veh, 3));
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input bit raw, input int n);
    for (int i = 0; i < n; i++) step(raw, 1'b0, 1'b1);
  endtask

  // Monitor: every edge produces one output sample to check.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      cmp("sensor_a", 32'(sensor_a), 32'(mon_e.sensor));
      cmp("stuck_a",  32'(stuck_a),  32'(mon_e.stuck));
      cmp("count_a",  32'(cnt_a),    32'(mon_e.cnt_a));
      cmp("sensor_b", 32'(sensor_b), 32'(mon_e.sensor));
      cmp("stuck_b",  32'(stuck_b),  32'(mon_e.stuck));
      cmp("count_b",  32'(cnt_b),    32'(mon_e.cnt_b));
    end
  end

  initial begin
    #1;
    // Reset
    step(0, 0, 0);
    step(0, 0, 0);
    cmp("rst_sensor", 32'(sensor_a), 0);
    cmp("rst_count", 32'(cnt_a), 0);
    cmp("rst_stuck", 32'(stuck_a), 0);

    // Steady high: request rises after edge D+1
    run(1, D + 1);
    cmp("deb_before", 32'(sensor_a), 0);
    run(1, 1);
    cmp("deb_after", 32'(sensor_a), 1);
    cmp("deb_count", 32'(cnt_a), 1);

    // Loop clears: request falls after edge H+2
    run(1, 5);
    run(0, H + 2);
    cmp("hold_before", 32'(sensor_a), 1);
    run(0, 1);
    cmp("hold_after", 32'(sensor_a), 0);
    run(0, 5);

    // Short drop while present: same vehicle, no new count
    run(1, 12);
    run(0, 4);
    run(1, 20);
    cmp("drop_sensor", 32'(sensor_a), 1);
    cmp("drop_count", 32'(cnt_a), 2);
    run(0, 25);

    // Glitches shorter than the debounce never count
    step(0, 1, 1);
    cmp("clr_count", 32'(cnt_a), 0);
    for (int g = 0; g < 3; g++) begin
      run(1, 5);
      run(0, 5);
    end
    cmp("glitch_sensor", 32'(sensor_a), 0);
    cmp("glitch_count", 32'(cnt_a), 0);

    // Saturation of the narrow counter, then clear coinciding with a new vehicle
    for (int v = 0; v < 5; v++) begin
      run(1, 10);
      run(0, 20);
    end
    cmp("sat_count_b", 32'(cnt_b), 3);
    cmp("sat_count_a", 32'(cnt_a), 5);
    run(1, 9);
    step(1, 1, 1);
    cmp("clr_inc_b", 32'(cnt_b), 1);
    cmp("clr_inc_a", 32'(cnt_a), 1);
    run(1, 3);
    run(0, 20);

    // Reset while holding
    for (int v = 0; v < 6; v++) begin
      run(1, 10);
      if (v < 5) run(0, 20);
    end
    run(0, 5);
    cmp("pre_rst_count", 32'(cnt_a), 7);
    cmp("pre_rst_state", 32'(dut_a.state_q), 32'(HOLD));
    step(0, 0, 0);
    cmp("midrst_sensor", 32'(sensor_a), 0);
    cmp("midrst_count", 32'(cnt_a), 0);
    cmp("midrst_state", 32'(dut_a.state_q), 32'(IDLE));
    run(0, 3);

    // Stuck-high loop
    run(1, 1200);
    cmp("stuck_flag", 32'(stuck_a), 32'(STUCK_EN));
    cmp("stuck_sensor", 32'(sensor_a), 32'(!STUCK_EN));
    run(0, 10);
    cmp("stuck_exit", 32'(stuck_a), 0);
    cmp("stuck_exit_sensor", 32'(sensor_a), 32'(!STUCK_EN));
    run(0, 20);

    // Random bursts with occasional clears and resets
    for (int b = 0; b < 60; b++) begin
      bit r;
      int len;
      r   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 14);
      for (int i = 0; i < len; i++)
        step(r, ($urandom_range(0, 19) == 0), ($urandom_range(0, 149) != 0));
    end

    run(0, 3);
    @(negedge clk);
    #1;
    cmp("queue_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vehicle_sensor_conditioner.md
VEHICLE_SENSOR_CONDITIONER -- requirements
Module: vehicle_sensor_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 8, consecutive synchronised-high cycles needed to declare a vehicle (legal range 2..255).
REQ-002 SHALL have parameter HOLD_CYCLES, default 16, cycles the request is held after the loop clears (legal range 2..255).
REQ-003 SHALL have parameter STUCK_CYCLES, default 1000, continuous PRESENT cycles before a stuck fault (legal range 4..65535).
REQ-004 SHALL have parameter CNT_W, default 8, width of vehicle_count.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit, reset; synchronous, active-low.
REQ-007 SHALL have port loop_raw, input, 1 bit, asynchronous, bouncy inductive-loop detector output.
REQ-008 SHALL have port count_clr, input, 1 bit, synchronous clear of vehicle_count.
REQ-009 SHALL have port sensor, output, 1 bit, registered, conditioned vehicle request to the traffic-light controller.
REQ-010 SHALL have port vehicle_count, output, CNT_W bits, registered, saturating count of detected vehicles.
REQ-011 SHALL have port stuck_fault, output, 1 bit, registered, loop stuck-high indication.

Function
REQ-012 SHALL pass loop_raw through a 2-flop synchroniser; loop_sync is the second flop's output, and no other logic SHALL sample loop_raw.
REQ-013 SHALL implement FSM states IDLE, ARM, PRESENT, HOLD, FAULT.
REQ-014 In IDLE, SHALL move to ARM with deb_cnt=1 when loop_sync=1; otherwise it SHALL stay in IDLE.
REQ-015 In ARM, SHALL move to PRESENT when loop_sync=1 and deb_cnt==DEBOUNCE_CYCLES-1, increment deb_cnt when loop_sync=1 otherwise, and return to IDLE when loop_sync=0.
REQ-016 Latency: with loop_raw high from before edge 0, sensor SHALL be 1 after edge DEBOUNCE_CYCLES+1; a glitch shorter than DEBOUNCE_CYCLES loop_sync cycles SHALL never assert sensor.
REQ-017 In PRESENT, SHALL move to HOLD and load hold_tmr=HOLD_CYCLES-1 when loop_sync=0.
REQ-018 In HOLD, SHALL return to PRESENT when loop_sync=1 without counting a new vehicle, move to IDLE when hold_tmr==0, and decrement hold_tmr otherwise.
REQ-019 Latency: with loop_raw low from before edge 0 while PRESENT, sensor SHALL be 0 after edge HOLD_CYCLES+2.
REQ-020 SHALL assert sensor=1 exactly in PRESENT and HOLD, and 0 in IDLE, ARM and FAULT.
REQ-021 SHALL increment vehicle_count only on ARM->PRESENT transitions, saturating at 2^CNT_W-1 with no wrap.
REQ-022 When count_clr=1, vehicle_count SHALL be 0 after the edge; if an increment occurs on the same edge, vehicle_count SHALL be 1.

Reset
REQ-023 When rst_n=0 at a clock edge, SHALL clear the synchroniser flops, deb_cnt, hold_tmr and stuck counter, set state to IDLE, and drive sensor=0, vehicle_count=0, stuck_fault=0.
REQ-024 Reset applied mid-operation (any state) SHALL take effect at that edge with no residual hold or debounce; rst_n SHALL have no asynchronous effect.

Configuration
REQ-025 Macro SENSOR_STUCK_DET_EN SHALL control stuck detection.
REQ-026 With SENSOR_STUCK_DET_EN defined: a stuck counter SHALL clear on entry to PRESENT and increment each PRESENT cycle; on reaching STUCK_CYCLES-1, state SHALL go to FAULT.
REQ-027 In FAULT, sensor SHALL be 0 and stuck_fault SHALL be 1; FAULT SHALL exit to IDLE after DEBOUNCE_CYCLES consecutive loop_sync=0 cycles, with stuck_fault=0 from that edge.
REQ-028 With SENSOR_STUCK_DET_EN undefined: FAULT and the stuck counter SHALL be absent, stuck_fault SHALL be tied 0, and the port list SHALL be unchanged.

Structure
REQ-029 Package sensor_pkg SHALL hold typedef sensor_state_t (IDLE, ARM, PRESENT, HOLD, FAULT) and the default parameter constants.
REQ-030 Sub-module sync_2ff SHALL implement the synchroniser with the same synchronous reset.

Verification
REQ-031 Scenario: loop_raw=1 from before edge 0, defaults -> sensor=1 after edge 9 and vehicle_count=1.
REQ-032 Scenario: loop_raw pulses high for 5 cycles, three times -> sensor stays 0 and vehicle_count stays 0.
REQ-033 Scenario: while PRESENT, loop_raw drops at edge 0 -> sensor=0 after edge 18; a second case with a 4-cycle drop -> sensor stays 1 and vehicle_count is unchanged.
REQ-034 Scenario: CNT_W=2, 5 vehicles -> vehicle_count=3; count_clr on the same edge as the 6th ARM->PRESENT -> vehicle_count=1.
REQ-035 Scenario: macro defined, loop_raw held high 1200 cycles -> stuck_fault=1 and sensor=0 from entry to FAULT; loop_raw low 10 cycles -> IDLE and stuck_fault=0. Macro undefined, same stimulus -> stuck_fault stays 0 and sensor stays 1.
REQ-036 Scenario: rst_n=0 for one edge while in HOLD with vehicle_count=7 -> after that edge sensor=0, vehicle_count=0, state IDLE.
